// File: rtl/instr_executor.sv
// Sequenced executor: fetches packed instructions from a register file, runs
// them through a signed ALU and hands each result out on a valid/ready port.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, start_addr     request a run beginning at start_addr
//   num_instr             number of instructions in the run (0..2^ADDR_W)
//   read_pointer          registered read address into the register file
//   instruction_word      {opc, op_a, op_b} read at read_pointer
//   res_valid/res_ready   result handshake
//   res_data/opc/addr/err result payload
//   busy, done            activity flag, end-of-run pulse

module instr_executor #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       num_instr,
  output logic [ADDR_W-1:0]     read_pointer,
  input  logic [4+2*OP_W-1:0]   instruction_word,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*OP_W-1:0]     res_data,
  output logic [3:0]            res_opc,
  output logic [ADDR_W-1:0]     res_addr,
  output logic                  res_err,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = 2 * OP_W;
  localparam int IW = 4 + RW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP,
    FIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W:0] remaining;
  logic            last;

  logic [3:0]           opc;
  logic [OP_W-1:0]      op_a;
  logic [OP_W-1:0]      op_b;
  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic signed [RW-1:0] alu_res;
  logic                 alu_err;
  logic                 b_zero;

  assign opc  = instruction_word[IW-1 -: 4];
  assign op_a = instruction_word[RW-1 -: OP_W];
  assign op_b = instruction_word[OP_W-1:0];

  assign a_ext  = {{OP_W{op_a[OP_W-1]}}, op_a};
  assign b_ext  = {{OP_W{op_b[OP_W-1]}}, op_b};
  assign b_zero = (op_b == '0);

  // The current accept retires the final instruction of the run.
  assign last = (remaining == (ADDR_W+1)'(1));

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);

  // Operands are widened first so MULT keeps the full product and
  // most-negative / -1 does not overflow.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (1'b1)
      opc[3]:         alu_err = 1'b1;
      (opc == 4'd0):  alu_res = '0;
      (opc == 4'd1):  alu_res = a_ext;
      (opc == 4'd2):  alu_res = b_ext;
      (opc == 4'd3):  alu_res = a_ext + b_ext;
      (opc == 4'd4):  alu_res = a_ext - b_ext;
      (opc == 4'd5):  alu_res = a_ext * b_ext;
      (opc == 4'd6): begin
        if (b_zero) alu_err = 1'b1;
        else        alu_res = a_ext / b_ext;
      end
      (opc == 4'd7): begin
        if (b_zero) alu_err = 1'b1;
        else        alu_res = a_ext % b_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (num_instr != '0) ? FETCH : FIN;
      end
      FETCH: state_d = RESP;
      RESP: begin
        if (res_ready)
          state_d = last ? FIN : FETCH;
      end
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      remaining    <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_opc      <= '0;
      res_addr     <= '0;
      res_err      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && num_instr != '0) begin
            read_pointer <= start_addr;
            remaining    <= num_instr;
          end
        end
        FETCH: begin
          res_data  <= alu_res;
          res_opc   <= opc;
          res_err   <= alu_err;
          res_addr  <= read_pointer;
          res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            remaining <= remaining - (ADDR_W+1)'(1);
            if (!last)
              read_pointer <= read_pointer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_executor.sv
// Directed bench for instr_executor: a queue of expected results computed
// from the opcode rules, checked every cycle the result port is valid.

module tb_instr_executor;

  localparam int AW = 5;
  localparam int OW = 32;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  opc;
    logic [4:0]  addr;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_instr;
  logic [AW-1:0] read_pointer;
  logic [67:0]   instruction_word;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [3:0]    res_opc;
  logic [AW-1:0] res_addr;
  logic          res_err;
  logic          busy;
  logic          done;

  logic [67:0] mem [0:31];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  exp_t exp_q[$];
  exp_t got_q[$];
  exp_t hd;
  exp_t gv;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_executor #(.ADDR_W(AW), .OP_W(OW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .num_instr        (num_instr),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_opc          (res_opc),
    .res_addr         (res_addr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [67:0] iw(input int opc, input int a, input int b);
    return {4'(opc), 32'(a), 32'(b)};
  endfunction

  function automatic exp_t model(input int addr);
    exp_t e;
    logic [67:0] w;
    longint a;
    longint b;
    w = mem[addr % 32];
    a = longint'($signed(w[63:32]));
    b = longint'($signed(w[31:0]));
    e.opc  = w[67:64];
    e.addr = 5'(addr % 32);
    e.err  = 1'b0;
    e.data = '0;
    case (int'(e.opc))
      0: e.data = '0;
      1: e.data = a;
      2: e.data = b;
      3: e.data = a + b;
      4: e.data = a - b;
      5: e.data = a * b;
      6: if (b == 0) e.err = 1'b1; else e.data = a / b;
      7: if (b == 0) e.err = 1'b1; else e.data = a % b;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    if (reset_n && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        hd = exp_q[0];
        chk("res_data", res_data, hd.data);
        chk("res_opc", res_opc, hd.opc);
        chk("res_err", res_err, hd.err);
        chk("res_addr", res_addr, hd.addr);
        chk("rp_hold", read_pointer, hd.addr);
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && res_valid && res_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      gv.data = res_data;
      gv.opc  = res_opc;
      gv.addr = res_addr;
      gv.err  = res_err;
      got_q.push_back(gv);
    end
  end

  task automatic run_seq(input int saddr, input int n,
                         input bit bp, input bit poke);
    int lat;
    int vcnt;
    int d0;
    bit seen;
    got_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model(saddr + i));
    d0 = done_cnt;
    lat = 0;
    vcnt = 0;
    seen = 1'b0;
    start = 1'b1;
    start_addr = 5'(saddr);
    num_instr = 6'(n);
    res_ready = !bp;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      start = poke && (lat == 3);
      if (start) begin
        start_addr = 5'd17;
        num_instr = 6'd1;
      end
      if (res_valid) vcnt++;
      res_ready = !bp || (vcnt > 5);
      seen = done;
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, 2 * n + 1 + (bp ? 5 : 0));
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_width", done, 0);
    chk("done_once", done_cnt - d0, 1);
    res_ready = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rp"}, read_pointer, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_data"}, res_data, 0);
    chk({tag, "_opc"}, res_opc, 0);
    chk({tag, "_addr"}, res_addr, 0);
    chk({tag, "_err"}, res_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int d0;
    int wl;
    int wrap_a [4] = '{30, 31, 0, 1};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0]  = iw(3, 5, 3);
    mem[1]  = iw(4, -4, 6);
    mem[2]  = iw(5, -7, 9);
    mem[3]  = iw(6, 7, 0);
    mem[4]  = iw(7, -7, 2);
    mem[5]  = iw(9, 3, 4);
    mem[6]  = iw(6, -7, 2);
    mem[7]  = iw(7, 7, -2);
    mem[8]  = iw(1, -123, 9);
    mem[9]  = iw(2, 4, 77);
    mem[10] = iw(0, 5, 6);
    mem[11] = iw(5, 32'h7fff_ffff, 32'h7fff_ffff);
    mem[12] = iw(5, int'(32'h8000_0000), -1);
    mem[13] = iw(6, int'(32'h8000_0000), -1);
    mem[30] = iw(3, 1, 2);
    mem[31] = iw(4, 10, 20);

    chk("model_add", model(0).data, 8);
    chk("model_mul", model(2).data, -63);
    chk("model_div0", model(3).err, 1);
    chk("model_big", model(11).data, 64'sh3fff_ffff_0000_0001);

    reset_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    num_instr = '0;
    res_ready = 1'b1;
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rp", read_pointer, 0);
    end

    run_seq(0, 3, 1'b0, 1'b1);
    chk("basic_r0", got_q[0].data, 8);
    chk("basic_r1", got_q[1].data, -10);
    chk("basic_r2", got_q[2].data, -63);
    chk("basic_a2", got_q[2].addr, 2);

    run_seq(0, 2, 1'b1, 1'b0);
    chk("bp_r0", got_q[0].data, 8);

    run_seq(30, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("wrap_addr", got_q[i].addr, wrap_a[i]);

    run_seq(3, 3, 1'b0, 1'b0);
    chk("err_d0", got_q[0].data, 0);
    chk("err_e0", got_q[0].err, 1);
    chk("err_d1", got_q[1].data, -1);
    chk("err_e1", got_q[1].err, 0);
    chk("err_d2", got_q[2].data, 0);
    chk("err_e2", got_q[2].err, 1);

    run_seq(0, 0, 1'b0, 1'b0);
    chk("zero_none", got_q.size(), 0);

    run_seq(6, 8, 1'b0, 1'b0);
    chk("ops_div", got_q[0].data, -3);
    chk("ops_mod", got_q[1].data, 1);
    chk("ops_mmin", got_q[6].data, 64'sd2147483648);

    for (int i = 0; i < 3; i++) exp_q.push_back(model(i));
    d0 = done_cnt;
    start = 1'b1;
    start_addr = '0;
    num_instr = 6'd3;
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wl = 0;
    while (!res_valid && wl < 10) begin
      @(negedge clk);
      wl++;
    end
    chk("mid_valid", res_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    res_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_busy", busy, 0);
    end
    chk("post_rp", read_pointer, 0);
    chk("post_nodone", done_cnt - d0, 0);

    run_seq(0, 3, 1'b0, 1'b0);
    chk("again_r1", got_q[1].data, -10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
